// File: rtl/relais_driver_if.sv
// Sample stream and relay status bundle for relais_driver.
// The controller drives the master side; relais_driver is the slave.
interface relais_driver_if #(
    parameter int W = 12
);
    logic         enable;
    logic         sample_valid;
    logic [W-1:0] sample;
    logic         drive;
    logic [1:0]   state;
    logic         dwell_busy;
    logic [15:0]  switch_count;

    modport master (
        output enable, sample_valid, sample,
        input  drive, state, dwell_busy, switch_count
    );

    modport slave (
        input  enable, sample_valid, sample,
        output drive, state, dwell_busy, switch_count
    );
endinterface

// File: rtl/relais_driver.sv
// Relay drive stage: hysteretic threshold compare, consecutive-sample debounce
// and minimum on/off dwell, with a saturating wear counter of drive transitions.
module relais_driver #(
    parameter int W       = 12,
    parameter int VT      = 2048,
    parameter int VH      = 205,
    parameter int DEB     = 4,
    parameter int MIN_ON  = 16,
    parameter int MIN_OFF = 16
) (
    input  logic      clk,
    input  logic      rst,
    relais_driver_if.slave io_bus
);
    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ARM_ON  = 2'd1,
        ST_ON      = 2'd2,
        ST_ARM_OFF = 2'd3
    } state_t;

    // Thresholds are clamped into the sample code range before narrowing.
    localparam int MAX_CODE = (1 << W) - 1;
    localparam int TH_ON_I  = (VT + VH > MAX_CODE) ? MAX_CODE : VT + VH;
    localparam int TH_OFF_I = (VT > VH) ? VT - VH : 0;
    localparam logic [W:0]  TH_ON     = TH_ON_I[W:0];
    localparam logic [W:0]  TH_OFF    = TH_OFF_I[W:0];
    localparam logic [7:0]  DEB_C     = 8'(DEB);
    localparam logic [15:0] MIN_ON_C  = 16'(MIN_ON);
    localparam logic [15:0] MIN_OFF_C = 16'(MIN_OFF);

    state_t      r_state;
    logic        r_drive;
    logic [7:0]  r_count;
    logic [15:0] r_dwell;
    logic        r_dwellBusy;
    logic [15:0] r_switchCount;

    logic [W:0]  w_sampleExt;
    logic        w_valid;
    logic        w_hi;
    logic        w_lo;
    logic        w_toward;
    logic [7:0]  w_countInc;
    logic [7:0]  w_countNext;
    logic        w_armDone;
    logic [15:0] w_dwellDec;
    logic [15:0] w_switchInc;

    assign w_sampleExt = {1'b0, io_bus.sample};
    assign w_valid     = io_bus.sample_valid;
    assign w_hi        = w_valid && (w_sampleExt > TH_ON);
    assign w_lo        = w_valid && (w_sampleExt < TH_OFF);
    assign w_toward    = ((r_state == ST_ON) || (r_state == ST_ARM_OFF)) ? w_lo : w_hi;
    assign w_countInc  = (r_count >= DEB_C) ? DEB_C : r_count + 8'd1;
    assign w_countNext = w_toward ? w_countInc : r_count;
    // A full debounce count switches only once the dwell was already zero before the edge.
    assign w_armDone   = (w_countNext == DEB_C) && (r_dwell == 16'd0);
    assign w_dwellDec  = (r_dwell == 16'd0) ? 16'd0 : r_dwell - 16'd1;
    assign w_switchInc = (r_switchCount == 16'hFFFF) ? r_switchCount : r_switchCount + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_OFF;
            r_drive       <= 1'b0;
            r_count       <= 8'd0;
            r_dwell       <= 16'd0;
            r_dwellBusy   <= 1'b0;
            r_switchCount <= 16'd0;
        end else begin
            r_dwell     <= w_dwellDec;
            r_dwellBusy <= (w_dwellDec != 16'd0);
            if (!io_bus.enable) begin
                // Disable forces the relay off immediately, overriding any minimum-on dwell.
                r_state <= ST_OFF;
                r_count <= 8'd0;
                if (r_drive) begin
                    r_drive       <= 1'b0;
                    r_dwell       <= MIN_OFF_C;
                    r_dwellBusy   <= (MIN_OFF_C != 16'd0);
                    r_switchCount <= w_switchInc;
                end
            end else begin
                case (r_state)
                    ST_OFF, ST_ARM_ON: begin
                        if (w_valid && !w_hi) begin
                            r_state <= ST_OFF;
                            r_count <= 8'd0;
                        end else if (w_armDone) begin
                            r_state       <= ST_ON;
                            r_drive       <= 1'b1;
                            r_count       <= 8'd0;
                            r_dwell       <= MIN_ON_C;
                            r_dwellBusy   <= (MIN_ON_C != 16'd0);
                            r_switchCount <= w_switchInc;
                        end else if (w_hi) begin
                            r_state <= ST_ARM_ON;
                            r_count <= w_countNext;
                        end
                    end
                    ST_ON, ST_ARM_OFF: begin
                        if (w_valid && !w_lo) begin
                            r_state <= ST_ON;
                            r_count <= 8'd0;
                        end else if (w_armDone) begin
                            r_state       <= ST_OFF;
                            r_drive       <= 1'b0;
                            r_count       <= 8'd0;
                            r_dwell       <= MIN_OFF_C;
                            r_dwellBusy   <= (MIN_OFF_C != 16'd0);
                            r_switchCount <= w_switchInc;
                        end else if (w_lo) begin
                            r_state <= ST_ARM_OFF;
                            r_count <= w_countNext;
                        end
                    end
                    default: begin
                        r_state <= ST_OFF;
                        r_count <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign io_bus.drive        = r_drive;
    assign io_bus.state        = r_state;
    assign io_bus.dwell_busy   = r_dwellBusy;
    assign io_bus.switch_count = r_switchCount;
endmodule

// File: tb/tb_relais_driver.sv
// Bench for relais_driver: default instance against a time-based reference model,
// plus a clamped-threshold instance and a fast-toggle instance for counter saturation.
module tb_relais_driver;
    localparam int A_VT = 2048, A_VH = 205, A_DEB = 4, A_MIN_ON = 16, A_MIN_OFF = 16;
    localparam int A_TH_ON  = (A_VT + A_VH > 4095) ? 4095 : A_VT + A_VH;
    localparam int A_TH_OFF = (A_VT > A_VH) ? A_VT - A_VH : 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    relais_driver_if #(.W(12)) busA ();
    relais_driver_if #(.W(12)) busB ();
    relais_driver_if #(.W(12)) busC ();

    relais_driver #(.W(12), .VT(A_VT), .VH(A_VH), .DEB(A_DEB), .MIN_ON(A_MIN_ON), .MIN_OFF(A_MIN_OFF))
        dutA (.clk(clk), .rst(rst), .io_bus(busA));
    relais_driver #(.W(12), .VT(4000), .VH(200), .DEB(4), .MIN_ON(16), .MIN_OFF(16))
        dutB (.clk(clk), .rst(rst), .io_bus(busB));
    relais_driver #(.W(12), .VT(2048), .VH(205), .DEB(1), .MIN_ON(0), .MIN_OFF(0))
        dutC (.clk(clk), .rst(rst), .io_bus(busC));

    int nCmp  = 0;
    int nFail = 0;

    // Reference model: relay on/off, run of consecutive qualifying samples, and the
    // absolute cycle index at which the dwell lockout ends.
    bit mOn;
    int mRun;
    int mLockUntil;
    int mNow;
    int mSwitches;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mOn = 1'b0;
        mRun = 0;
        mLockUntil = 0;
        mNow = 0;
        mSwitches = 0;
    endtask

    task automatic modelToggle();
        mOn = !mOn;
        mRun = 0;
        if (mSwitches < 65535) mSwitches++;
        mLockUntil = mNow + (mOn ? A_MIN_ON : A_MIN_OFF);
    endtask

    task automatic modelStep(input bit en, input bit v, input int s);
        int dwellBefore;
        bit toward;
        dwellBefore = (mLockUntil > mNow) ? mLockUntil - mNow : 0;
        mNow++;
        if (!en) begin
            mRun = 0;
            if (mOn) modelToggle();
        end else begin
            toward = mOn ? (v && s < A_TH_OFF) : (v && s > A_TH_ON);
            if (toward) mRun = (mRun + 1 > A_DEB) ? A_DEB : mRun + 1;
            else if (v) mRun = 0;
            if (mRun == A_DEB && dwellBefore == 0) modelToggle();
        end
    endtask

    task automatic checkOutput(input string tag);
        int expState;
        expState = mOn ? ((mRun > 0) ? 3 : 2) : ((mRun > 0) ? 1 : 0);
        checkEq({tag, ".drive"}, 32'(busA.drive), 32'(mOn));
        checkEq({tag, ".state"}, 32'(busA.state), 32'(expState));
        checkEq({tag, ".dwell_busy"}, 32'(busA.dwell_busy), 32'(mLockUntil > mNow));
        checkEq({tag, ".switch_count"}, 32'(busA.switch_count), 32'(mSwitches));
    endtask

    task automatic applyStimulus(input string tag, input bit en, input bit v, input int s);
        busA.enable       = en;
        busA.sample_valid = v;
        busA.sample       = 12'(s);
        @(posedge clk);
        #1;
        modelStep(en, v, s);
        checkOutput(tag);
    endtask

    task automatic pickSample(output int s);
        case ($urandom_range(0, 7))
            0: s = A_TH_ON;
            1: s = A_TH_ON + 1;
            2: s = A_TH_OFF;
            3: s = A_TH_OFF - 1;
            4: s = 2048;
            5: s = 2300;
            6: s = 1000;
            default: s = $urandom_range(0, 4095);
        endcase
    endtask

    initial begin
        int s;
        int expCount;
        rst = 1'b1;
        busA.enable = 1'b0; busA.sample_valid = 1'b0; busA.sample = '0;
        busB.enable = 1'b0; busB.sample_valid = 1'b0; busB.sample = '0;
        busC.enable = 1'b0; busC.sample_valid = 1'b0; busC.sample = '0;
        modelReset();
        #12;
        checkOutput("reset");
        rst = 1'b0;

        // Idle at the threshold centre never switches.
        for (int i = 0; i < 10; i++) applyStimulus("idle", 1'b1, 1'b1, 2048);

        // Basic switch and the full minimum-on dwell.
        for (int i = 0; i < 5; i++) applyStimulus("basic", 1'b1, 1'b1, 2300);
        for (int i = 0; i < 18; i++) applyStimulus("basicDwell", 1'b1, 1'b0, 0);
        checkEq("basic.onBeforeReset", 32'(busA.drive), 32'd1);

        // Asynchronous reset mid-cycle while the relay is on.
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkOutput("midReset");
        #1 rst = 1'b0;

        // Equality with TH_ON breaks the debounce run.
        applyStimulus("hystBreak", 1'b1, 1'b1, 2300);
        applyStimulus("hystBreak", 1'b1, 1'b1, 2300);
        applyStimulus("hystBreak", 1'b1, 1'b1, A_TH_ON);
        applyStimulus("hystBreak", 1'b1, 1'b1, 2300);
        for (int i = 0; i < 4; i++) applyStimulus("hystIdle", 1'b1, 1'b0, 0);

        // Invalid cycles interleaved between qualifying samples hold the count.
        applyStimulus("interleave", 1'b1, 1'b1, 2300);
        applyStimulus("interleave", 1'b1, 1'b0, 0);
        applyStimulus("interleave", 1'b1, 1'b1, 2300);
        applyStimulus("interleave", 1'b1, 1'b0, 0);
        applyStimulus("interleave", 1'b1, 1'b0, 0);
        applyStimulus("interleave", 1'b1, 1'b1, 2300);
        applyStimulus("interleave", 1'b1, 1'b0, 0);
        applyStimulus("interleave", 1'b1, 1'b1, 2300);
        for (int i = 0; i < 20; i++) applyStimulus("settle", 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) applyStimulus("goOff", 1'b1, 1'b1, 1000);
        for (int i = 0; i < 20; i++) applyStimulus("settle", 1'b1, 1'b0, 0);

        // Dwell blocking: off request completes only after the minimum-on time.
        for (int i = 0; i < 4; i++) applyStimulus("dwellOn", 1'b1, 1'b1, 2300);
        for (int i = 0; i < 4; i++) applyStimulus("dwellArmOff", 1'b1, 1'b1, 1000);
        for (int i = 0; i < 20; i++) applyStimulus("dwellWait", 1'b1, 1'b0, 0);

        // Enable override while the minimum-on dwell is still running.
        for (int i = 0; i < 4; i++) applyStimulus("enOn", 1'b1, 1'b1, 2300);
        for (int i = 0; i < 6; i++) applyStimulus("enHold", 1'b1, 1'b0, 0);
        for (int i = 0; i < 20; i++) applyStimulus("enLow", 1'b0, 1'b1, 2300);

        // Randomized traffic around both thresholds.
        for (int i = 0; i < 1500; i++) begin
            pickSample(s);
            applyStimulus("random", ($urandom_range(0, 31) != 0), ($urandom_range(0, 2) != 0), s);
        end

        // Clamped TH_ON: even full-scale samples never switch on.
        busB.enable = 1'b1;
        busB.sample_valid = 1'b1;
        for (int i = 0; i < 52; i++) begin
            busB.sample = (i < 12) ? 12'hFFF : 12'($urandom_range(0, 4095));
            @(posedge clk);
            #1;
            checkEq("clamp.drive", 32'(busB.drive), 32'd0);
            checkEq("clamp.state", 32'(busB.state), 32'd0);
            checkEq("clamp.switch_count", 32'(busB.switch_count), 32'd0);
        end

        // DEB=1, no dwell: one transition per valid sample until the counter saturates.
        busC.enable = 1'b1;
        busC.sample_valid = 1'b1;
        for (int k = 1; k <= 65540; k++) begin
            busC.sample = (k % 2 == 1) ? 12'd3000 : 12'd500;
            @(posedge clk);
            #1;
            expCount = (k > 65535) ? 65535 : k;
            checkEq("sat.drive", 32'(busC.drive), 32'(k % 2));
            checkEq("sat.switch_count", 32'(busC.switch_count), 32'(expCount));
            if (k <= 2) begin
                checkEq("sat.state", 32'(busC.state), (k % 2 == 1) ? 32'd2 : 32'd0);
                checkEq("sat.dwell_busy", 32'(busC.dwell_busy), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule

// File: doc/relais_driver.md
Name: relais_driver

Overview:
- Digital control stage placed directly upstream of the hysteretic relay switch model.
- Consumes a sampled control-voltage stream (unsigned ADC-style codes), applies threshold-with-hysteresis comparison, consecutive-sample debounce and minimum on/off dwell timing.
- Produces the single registered drive bit that controls the relay, plus status and a switch-cycle counter for wear accounting.

Parameters:
- W, 12, sample width in bits.
- VT, 2048, threshold centre code (mirrors relay vt).
- VH, 205, hysteresis half-width code (mirrors relay vh).
- DEB, 4, consecutive qualifying valid samples required to switch (1..255).
- MIN_ON, 16, minimum clock cycles drive stays 1 after rising (0..65535).
- MIN_OFF, 16, minimum clock cycles drive stays 0 after falling (0..65535).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  master enable; low forces relay off.
- sample_valid  in  1  qualifies sample for one cycle.
- sample  in  W  unsigned control code.
- drive  out  1  relay drive, registered.
- state  out  2  0=OFF, 1=ARM_ON, 2=ON, 3=ARM_OFF.
- dwell_busy  out  1  high while dwell counter is nonzero.
- switch_count  out  16  saturating count of drive transitions.

Behaviour:
- Reset (async, immediate): drive=0, state=OFF, debounce count=0, dwell=0, dwell_busy=0, switch_count=0.
- Thresholds computed in W+1 bits: TH_ON=min(VT+VH, 2^W-1), TH_OFF=max(VT-VH, 0).
- Qualifying samples: hi when sample > TH_ON (strict); lo when sample < TH_OFF (strict). Equality never qualifies.
- Only cycles with sample_valid=1 advance or clear the debounce count. Invalid cycles hold all state except the dwell counter.
- OFF:
  - valid hi → ARM_ON, count=1.
  - If DEB=1 and dwell=0, go directly to ON on that edge.
- ARM_ON:
  - valid hi → count+1, saturating at DEB.
  - valid non-hi → OFF, count=0.
  - When count reaches DEB and dwell=0 → ON.
  - While dwell>0 at count=DEB, stay in ARM_ON.
- ON / ARM_OFF: mirror image of OFF / ARM_ON using lo.
- Entering ON (on that clock edge):
  - drive←1, dwell←MIN_ON, count←0, switch_count+1 (saturating at 0xFFFF).
  - Latency: the DEB-th qualifying sample is captured and drive changes on the same rising edge (visible one cycle after the sample is presented).
- Entering OFF from ARM_OFF: drive←0, dwell←MIN_OFF, count←0, switch_count+1.
- Dwell counter: decrements by 1 every cycle while nonzero, independent of sample_valid. dwell_busy = (dwell != 0), registered.
- Simultaneous completion: a switch when dwell reaches 0 may occur on the edge where dwell goes 1→0 only if the count was already DEB. The rule is that dwell must equal 0 before the edge.
- enable low (any state):
  - Next edge: state=OFF, count=0.
  - If drive was 1: drive←0, dwell←MIN_OFF, switch_count+1. This overrides MIN_ON.
  - If drive was 0: dwell is unchanged.
  - Samples are ignored while enable=0.
  - Re-enable starts debounce from OFF.
- Mid-operation reset: immediate return to reset values, including switch_count.
- No combinational path from inputs to outputs.

Test Plan:
- Reset/idle: assert rst mid-cycle with drive=1 → drive, state, switch_count are 0 asynchronously. Samples 2048 forever → drive stays 0.
- Basic switch: DEB=4, MIN_ON=16. Five valid samples 2300 back-to-back → state 1 after edge 1; drive=1 after edge 4; switch_count=1; dwell_busy high for 16 cycles.
- Hysteresis/debounce break:
  - Valid samples 2300, 2300, 2253 (=TH_ON, non-qualifying), 2300 → returns to OFF, count restarts, no switch.
  - Invalid cycles interleaved between four 2300 samples → still switches on the 4th valid sample.
- Dwell blocking: switch ON, then immediately four valid samples 1000 → state=ARM_OFF, drive stays 1 until dwell reaches 0, then drive=0 on the first edge with dwell=0. switch_count=2.
- Enable override: drive=1 with dwell=10; deassert enable → drive=0 next edge, state=OFF, switch_count+1, dwell_busy high for MIN_OFF cycles.
- Saturation/edge params: VT=4000, VH=200 → TH_ON clamps to 4095, so no sample switches ON. Force switch_count near 0xFFFF via many toggles (DEB=1, MIN_*=0) → count holds at 0xFFFF.
